mem_stage: RTL and testbench



---
 rtl/y86_pkg.sv | 43 ++++
 rtl/y86_dmem.sv | 34 +++
 rtl/mem_stage.sv | 123 ++++++++++++
 tb/tb_mem_stage.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Y86-64 shared definitions: instruction codes, status codes, memory-stage states
// and the opcode decode helpers used to classify data-memory accesses.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP,
    S_HALT
  } mem_state_t;

  function automatic logic is_mem_rd(input logic [3:0] ic);
    return (ic == IMRMOVQ) || (ic == IRET) || (ic == IPOPQ);
  endfunction

  function automatic logic is_mem_wr(input logic [3:0] ic);
    return (ic == IRMMOVQ) || (ic == ICALL) || (ic == IPUSHQ);
  endfunction

  // ret/popq address the stack through valA; everything else through valE.
  function automatic logic addr_from_vala(input logic [3:0] ic);
    return (ic == IRET) || (ic == IPOPQ);
  endfunction

endpackage

// File: rtl/y86_dmem.sv
// Byte-addressed data memory: combinational 64-bit little-endian read, synchronous
// 8-lane write; no reset, no backpressure. Callers keep accesses within bounds.
module y86_dmem
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [$clog2(MEM_BYTES)-1:0] addr,
  input  logic [63:0]                  wr_data,
  output logic [63:0]                  rd_data
);

  localparam int AW = $clog2(MEM_BYTES);

  logic [7:0] mem [MEM_BYTES];

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < 8; i++) begin
      rd_data[8*i +: 8] = mem[addr + AW'(i)];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        mem[addr + AW'(i)] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Y86-64 memory stage, one instruction in flight: legal accesses answer MEM_LAT+1 cycles
// after accept, all else 1 cycle; results hold while out_ready is low; non-AOK halts until reset.
module mem_stage
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int MEM_LAT   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  input  logic        cnd,
  input  logic        instr_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_icode,
  output logic [63:0] out_valE,
  output logic [63:0] out_valM,
  output logic        out_cnd,
  output logic [2:0]  out_stat,
  output logic        halted
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam int CW = $clog2(MEM_LAT + 1);

  mem_state_t    state, state_nxt;
  logic [CW-1:0] cnt;
  logic [AW-1:0] addr_q;
  logic [63:0]   wdat_q, rd_data, in_addr;
  logic          rd_q, wr_q;
  logic          in_rd, in_wr, in_mem_ok, accept, last_cyc;
  logic [2:0]    in_stat;

  assign accept    = (state == S_IDLE) && in_valid;
  assign last_cyc  = (state == S_BUSY) && (cnt == CW'(1));
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_RESP);
  assign halted    = (state == S_HALT);

  // Status is resolved at accept so errored ops never reach BUSY and never write.
  always_comb begin
    in_rd   = is_mem_rd(icode);
    in_wr   = is_mem_wr(icode);
    in_addr = addr_from_vala(icode) ? valA : valE;
    if (instr_err || (icode > IPOPQ)) begin
      in_stat = SINS;
    end else if (icode == IHALT) begin
      in_stat = SHLT;
    end else if ((in_rd || in_wr) && (in_addr > 64'(MEM_BYTES - 8))) begin
      in_stat = SADR;
    end else begin
      in_stat = SAOK;
    end
    in_mem_ok = (in_rd || in_wr) && (in_stat == SAOK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid) state_nxt = in_mem_ok ? S_BUSY : S_RESP;
      S_BUSY:  if (cnt == CW'(1)) state_nxt = S_RESP;
      S_RESP:  if (out_ready) state_nxt = (out_stat == SAOK) ? S_IDLE : S_HALT;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      addr_q    <= '0;
      wdat_q    <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      out_icode <= '0;
      out_valE  <= '0;
      out_valM  <= '0;
      out_cnd   <= 1'b0;
      out_stat  <= SAOK;
    end else if (accept) begin
      cnt       <= CW'(MEM_LAT);
      addr_q    <= in_addr[AW-1:0];
      wdat_q    <= (icode == ICALL) ? valP : valA;
      rd_q      <= in_rd;
      wr_q      <= in_wr;
      out_icode <= icode;
      out_valE  <= valE;
      out_valM  <= '0;
      out_cnd   <= cnd;
      out_stat  <= in_stat;
    end else if (state == S_BUSY) begin
      cnt <= cnt - CW'(1);
      if (last_cyc && rd_q) begin
        out_valM <= rd_data;
      end
    end
  end

  y86_dmem #(
    .MEM_BYTES(MEM_BYTES)
  ) u_dmem (
    .clk    (clk),
    .wr_en  (last_cyc && wr_q),
    .addr   (addr_q),
    .wr_data(wdat_q),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage: a byte-array reference memory predicts each
// response, which a separate monitor compares (plus latency and hold stability) on out_valid.
`timescale 1ns/1ps
module tb_mem_stage;

  localparam int MEM_BYTES = 1024;
  localparam int MEM_LAT   = 2;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, cnd, instr_err;
  logic        out_valid, out_ready, out_cnd, halted;
  logic [3:0]  icode, out_icode;
  logic [63:0] valE, valA, valP, out_valE, out_valM;
  logic [2:0]  out_stat;

  always #5 clk = ~clk;

  mem_stage #(
    .MEM_BYTES(MEM_BYTES),
    .MEM_LAT  (MEM_LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .icode    (icode),
    .valE     (valE),
    .valA     (valA),
    .valP     (valP),
    .cnd      (cnd),
    .instr_err(instr_err),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_icode(out_icode),
    .out_valE (out_valE),
    .out_valM (out_valM),
    .out_cnd  (out_cnd),
    .out_stat (out_stat),
    .halted   (halted)
  );

  typedef struct {
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valM;
    logic        cnd;
    logic [2:0]  stat;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] ref_mem [MEM_BYTES];
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  int         rdy_mode = 1;  // 0 random, 1 always ready, 2 stalled

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  task automatic note_timeout(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired, required event never seen", nm);
  endtask

  // Reference: status by priority, then an 8-byte little-endian access on a flat byte array.
  function automatic exp_t model(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                                 input logic [63:0] p, input logic c, input logic err);
    exp_t        x;
    logic [63:0] addr, wdat;
    bit          rd, wr;
    rd   = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
    wr   = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
    addr = (ic == 4'h9 || ic == 4'hB) ? a : e;
    x.icode   = ic;
    x.valE    = e;
    x.cnd     = c;
    x.valM    = 64'd0;
    x.acc_cyc = cyc;
    if (err || ic > 4'hB)                                 x.stat = 3'd4;
    else if (ic == 4'h0)                                  x.stat = 3'd2;
    else if ((rd || wr) && addr > 64'(MEM_BYTES - 8))     x.stat = 3'd3;
    else                                                  x.stat = 3'd1;
    if (x.stat == 3'd1 && rd)
      for (int i = 0; i < 8; i++) x.valM = x.valM + (64'(ref_mem[int'(addr) + i]) << (8 * i));
    if (x.stat == 3'd1 && wr) begin
      wdat = (ic == 4'h8) ? p : a;
      for (int i = 0; i < 8; i++) ref_mem[int'(addr) + i] = wdat[8*i +: 8];
    end
    x.lat = (x.stat == 3'd1 && (rd || wr)) ? MEM_LAT + 1 : 1;
    return x;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                       input logic [63:0] p, input logic c, input logic err, input bit track);
    int w = 0;
    while (!in_ready && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      note_timeout("accept_wait");
      return;
    end
    in_valid = 1'b1; icode = ic; valE = e; valA = a; valP = p; cnd = c; instr_err = err;
    if (track) exp_q.push_back(model(ic, e, a, p, c, err));
    @(negedge clk);
    in_valid  = 1'b0;
    icode     = 4'($urandom);
    valE      = {$urandom, $urandom};
    valA      = {$urandom, $urandom};
    valP      = {$urandom, $urandom};
    cnd       = 1'($urandom);
    instr_err = 1'($urandom);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_icode", out_icode, 0);
    chk("rst_out_valE", out_valE, 0);
    chk("rst_out_valM", out_valM, 0);
    chk("rst_out_cnd", out_cnd, 0);
    chk("rst_out_stat", out_stat, 1);
    chk("rst_halted", halted, 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || out_valid) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0 || out_valid) note_timeout("drain");
  endtask

  task automatic wait_halt();
    int w = 0;
    while (!halted && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("halted_set", halted, 1);
    chk("halt_in_ready", in_ready, 0);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      icode    = 4'h1;
      @(negedge clk);
      chk("halt_ignores_in", {halted, in_ready, out_valid}, 3'b100);
    end
    in_valid = 1'b0;
  endtask

  // out_ready changes just after the rising edge so the monitor sees it settled.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pop on the first cycle of each response, then demand stable outputs until taken.
  initial begin
    exp_t         x;
    bit           seen;
    logic [135:0] snap;
    seen = 0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 0;
      end else if (out_valid) begin
        if (!seen) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_out_valid: got icode 0x%0h, required no response", out_icode);
          end else begin
            x = exp_q.pop_front();
            chk("out_icode", out_icode, x.icode);
            chk("out_valE", out_valE, x.valE);
            chk("out_valM", out_valM, x.valM);
            chk("out_cnd", out_cnd, x.cnd);
            chk("out_stat", out_stat, x.stat);
            chk("latency", cyc - x.acc_cyc, x.lat);
          end
          snap = {out_icode, out_valE, out_valM, out_cnd, out_stat};
          seen = 1;
        end else begin
          chk("hold_stable", {out_icode, out_valE, out_valM, out_cnd, out_stat}, snap);
        end
        chk("in_ready_busy", in_ready, 0);
        if (out_ready) seen = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  ric;
    logic [63:0] lo, big;
    int          w;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
    rst_n = 1'b0; in_valid = 1'b0; icode = 4'h0; valE = '0; valA = '0; valP = '0;
    cnd = 1'b0; instr_err = 1'b0;
    @(negedge clk);
    do_reset();

    for (int a = 0; a < MEM_BYTES; a += 8) issue(4'h4, 64'(a), 64'd0, 64'd0, 1'b0, 1'b0, 1);
    drain();

    issue(4'h4, 64'h10, 64'h1122334455667788, 64'h0, 1'b1, 1'b0, 1);
    issue(4'h5, 64'h10, 64'h0, 64'h0, 1'b0, 1'b0, 1);
    issue(4'h5, 64'h13, 64'h0, 64'h0, 1'b0, 1'b0, 1);
    issue(4'hA, 64'h3F8, 64'hABCD, 64'h0, 1'b0, 1'b0, 1);
    issue(4'hB, 64'h400, 64'h3F8, 64'h0, 1'b0, 1'b0, 1);
    issue(4'h8, 64'h3F0, 64'h0, 64'h40, 1'b0, 1'b0, 1);
    issue(4'h9, 64'h3F8, 64'h3F0, 64'h0, 1'b0, 1'b0, 1);
    issue(4'h2, 64'h55, 64'h55, 64'h0, 1'b0, 1'b0, 1);
    issue(4'h2, 64'h66, 64'h66, 64'h0, 1'b1, 1'b0, 1);
    drain();

    rdy_mode = 2;
    issue(4'h4, 64'h40, 64'hCAFE_F00D_1234_5678, 64'h0, 1'b1, 1'b0, 1);
    w = 0;
    while (!out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!out_valid) note_timeout("bp_out_valid");
    repeat (5) @(negedge clk);
    rdy_mode = 1;
    w = 0;
    while (out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_after_hs", in_ready, 1);
    issue(4'h5, 64'h40, 64'h0, 64'h0, 1'b0, 1'b0, 1);
    drain();

    rdy_mode = 0;
    for (int k = 0; k < 250; k++) begin
      ric = 4'($urandom_range(1, 11));
      lo  = 64'($urandom_range(0, MEM_BYTES - 8));
      big = {$urandom, $urandom};
      if (ric == 4'h9 || ric == 4'hB) issue(ric, big, lo, {$urandom, $urandom}, 1'($urandom), 1'b0, 1);
      else                            issue(ric, lo, big, {$urandom, $urandom}, 1'($urandom), 1'b0, 1);
    end
    drain();
    rdy_mode = 1;
    @(negedge clk);

    issue(4'h4, 64'h20, 64'h0, 64'h0, 1'b0, 1'b0, 1);
    drain();
    issue(4'h4, 64'h20, 64'h5A5A_A5A5_DEAD_BEEF, 64'h0, 1'b0, 1'b0, 0);
    do_reset();
    issue(4'h5, 64'h20, 64'h0, 64'h0, 1'b0, 1'b0, 1);
    drain();

    issue(4'h4, 64'h3F9, 64'hFFEE_DDCC_BBAA_9988, 64'h0, 1'b0, 1'b0, 1);
    wait_halt();
    do_reset();
    issue(4'h5, 64'h3F8, 64'h0, 64'h0, 1'b0, 1'b0, 1);
    issue(4'h5, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 1);
    drain();

    issue(4'h0, 64'h7, 64'h0, 64'h0, 1'b1, 1'b0, 1);
    wait_halt();
    do_reset();
    issue(4'hC, 64'h10, 64'h0, 64'h0, 1'b0, 1'b0, 1);
    wait_halt();
    do_reset();
    issue(4'h6, 64'h99, 64'h0, 64'h0, 1'b1, 1'b1, 1);
    wait_halt();
    do_reset();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
